mipi_rx_packet_decoder: RTL and testbench

MIPI_RX_PACKET_DECODER -- requirements
Module: mipi_rx_packet_decoder

---
 rtl/mipi_rx_pkg.sv | 24 ++
 rtl/mipi_rx_be_gen.sv | 27 ++
 rtl/mipi_rx_packet_decoder.sv | 162 ++++++++++++++++
 tb/tb_mipi_rx_packet_decoder.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/mipi_rx_pkg.sv
// Shared types and constants for the MIPI RX packet decoder.
// Holds the FSM state encoding, sync/long-packet defaults and common data types.
package mipi_rx_pkg;

    localparam logic [7:0] SYNC_BYTE_DEF   = 8'hB8;
    localparam logic [5:0] LONG_DT_MIN_DEF = 6'h10;

    localparam logic [5:0] DT_FS    = 6'h00;
    localparam logic [5:0] DT_FE    = 6'h01;
    localparam logic [5:0] DT_RAW8  = 6'h2A;
    localparam logic [5:0] DT_RAW10 = 6'h2B;

    localparam logic [3:0] BE_ALL  = 4'b1111;
    localparam logic [3:0] BE_NONE = 4'b0000;

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        PAYLOAD,
        DONE,
        ERR
    } state_t;

endpackage

// File: rtl/mipi_rx_be_gen.sv
// Maps the remaining payload byte count onto byte enables for the current
// 4-byte word and flags the word that completes the packet.
module mipi_rx_be_gen
    import mipi_rx_pkg::*;
(
    input  logic [15:0] remaining,
    output logic [3:0]  be,
    output logic        last
);

    always_comb begin
        be   = BE_NONE;
        last = (remaining <= 16'd4);
        if (remaining > 16'd4) begin
            be = BE_ALL;
        end else begin
            case (remaining[2:0])
                3'd1:    be = 4'b0001;
                3'd2:    be = 4'b0011;
                3'd3:    be = 4'b0111;
                3'd4:    be = BE_ALL;
                default: be = BE_NONE;
            endcase
        end
    end

endmodule

// File: rtl/mipi_rx_packet_decoder.sv
// CSI-2 style packet decoder for an aligned 4-lane byte stream: checks sync,
// decodes the packet header and emits payload words with byte enables.
module mipi_rx_packet_decoder
    import mipi_rx_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEF,
    parameter logic [5:0] LONG_DT_MIN = LONG_DT_MIN_DEF
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        lane_valid_i,
    input  logic [31:0] lane_byte_i,
    output logic        payload_valid_o,
    output logic [31:0] payload_o,
    output logic [3:0]  payload_be_o,
    output logic        payload_last_o,
    output logic        header_valid_o,
    output logic [1:0]  vc_o,
    output logic [5:0]  dt_o,
    output logic [15:0] wc_o,
    output logic        sync_err_o,
    output logic        trunc_err_o
);

    state_t      state, state_nxt;
    logic [15:0] remaining, remaining_nxt;
    logic        prev_valid;

    logic        payload_valid_nxt;
    logic [31:0] payload_nxt;
    logic [3:0]  payload_be_nxt;
    logic        payload_last_nxt;
    logic        header_valid_nxt;
    logic [1:0]  vc_nxt;
    logic [5:0]  dt_nxt;
    logic [15:0] wc_nxt;
    logic        sync_err_nxt;
    logic        trunc_err_nxt;

    logic [3:0]  be_word;
    logic        last_word;
    logic [15:0] hdr_wc;
    logic        burst_start;

    assign hdr_wc      = lane_byte_i[23:8];
    assign burst_start = lane_valid_i && !prev_valid;

    mipi_rx_be_gen u_be_gen (
        .remaining (remaining),
        .be        (be_word),
        .last      (last_word)
    );

    always_comb begin
        state_nxt         = state;
        remaining_nxt     = remaining;
        vc_nxt            = vc_o;
        dt_nxt            = dt_o;
        wc_nxt            = wc_o;
        payload_valid_nxt = 1'b0;
        payload_nxt       = '0;
        payload_be_nxt    = '0;
        payload_last_nxt  = 1'b0;
        header_valid_nxt  = 1'b0;
        sync_err_nxt      = 1'b0;
        trunc_err_nxt     = 1'b0;

        case (state)
            IDLE: begin
                if (burst_start) begin
                    if (lane_byte_i == {4{SYNC_BYTE}}) begin
                        state_nxt = HEADER;
                    end else begin
                        sync_err_nxt = 1'b1;
                        state_nxt    = ERR;
                    end
                end
            end

            HEADER: begin
                if (!lane_valid_i) begin
                    trunc_err_nxt = 1'b1;
                    state_nxt     = IDLE;
                end else begin
                    header_valid_nxt = 1'b1;
                    vc_nxt           = lane_byte_i[7:6];
                    dt_nxt           = lane_byte_i[5:0];
                    wc_nxt           = hdr_wc;
                    if (lane_byte_i[5:0] < LONG_DT_MIN || hdr_wc == 16'd0) begin
                        state_nxt = DONE;
                    end else begin
                        remaining_nxt = hdr_wc;
                        state_nxt     = PAYLOAD;
                    end
                end
            end

            PAYLOAD: begin
                if (!lane_valid_i) begin
                    trunc_err_nxt = 1'b1;
                    remaining_nxt = '0;
                    state_nxt     = IDLE;
                end else begin
                    payload_valid_nxt = 1'b1;
                    payload_nxt       = lane_byte_i;
                    payload_be_nxt    = be_word;
                    payload_last_nxt  = last_word;
                    // Clamp at zero on the final word so odd counts never wrap.
                    if (last_word) begin
                        remaining_nxt = '0;
                        state_nxt     = DONE;
                    end else begin
                        remaining_nxt = remaining - 16'd4;
                    end
                end
            end

            DONE, ERR: begin
                if (!lane_valid_i) begin
                    state_nxt = IDLE;
                end
            end

            default: state_nxt = IDLE;
        endcase
    end

    // prev_valid resets high so a burst already in flight at reset release
    // is ignored until lane_valid_i has been seen low.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state           <= IDLE;
            remaining       <= '0;
            prev_valid      <= 1'b1;
            payload_valid_o <= 1'b0;
            payload_o       <= '0;
            payload_be_o    <= '0;
            payload_last_o  <= 1'b0;
            header_valid_o  <= 1'b0;
            vc_o            <= '0;
            dt_o            <= '0;
            wc_o            <= '0;
            sync_err_o      <= 1'b0;
            trunc_err_o     <= 1'b0;
        end else begin
            state           <= state_nxt;
            remaining       <= remaining_nxt;
            prev_valid      <= lane_valid_i;
            payload_valid_o <= payload_valid_nxt;
            payload_o       <= payload_nxt;
            payload_be_o    <= payload_be_nxt;
            payload_last_o  <= payload_last_nxt;
            header_valid_o  <= header_valid_nxt;
            vc_o            <= vc_nxt;
            dt_o            <= dt_nxt;
            wc_o            <= wc_nxt;
            sync_err_o      <= sync_err_nxt;
            trunc_err_o     <= trunc_err_nxt;
        end
    end

endmodule

// File: tb/tb_mipi_rx_packet_decoder.sv
// Directed-vector bench for mipi_rx_packet_decoder with hand-computed results.
module tb_mipi_rx_packet_decoder;

    localparam logic [31:0] SYNC = 32'hB8B8B8B8;

    localparam logic [4:0] F_NONE = 5'b00000;
    localparam logic [4:0] F_PV   = 5'b10000;
    localparam logic [4:0] F_LAST = 5'b01000;
    localparam logic [4:0] F_HV   = 5'b00100;
    localparam logic [4:0] F_SE   = 5'b00010;
    localparam logic [4:0] F_TE   = 5'b00001;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        lane_valid_i;
    logic [31:0] lane_byte_i;
    logic        payload_valid_o;
    logic [31:0] payload_o;
    logic [3:0]  payload_be_o;
    logic        payload_last_o;
    logic        header_valid_o;
    logic [1:0]  vc_o;
    logic [5:0]  dt_o;
    logic [15:0] wc_o;
    logic        sync_err_o;
    logic        trunc_err_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mipi_rx_packet_decoder #(
        .SYNC_BYTE   (8'hB8),
        .LONG_DT_MIN (6'h10)
    ) dut (
        .clk_i           (clk),
        .reset_i         (reset_i),
        .lane_valid_i    (lane_valid_i),
        .lane_byte_i     (lane_byte_i),
        .payload_valid_o (payload_valid_o),
        .payload_o       (payload_o),
        .payload_be_o    (payload_be_o),
        .payload_last_o  (payload_last_o),
        .header_valid_o  (header_valid_o),
        .vc_o            (vc_o),
        .dt_o            (dt_o),
        .wc_o            (wc_o),
        .sync_err_o      (sync_err_o),
        .trunc_err_o     (trunc_err_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] flags();
        return {27'b0, payload_valid_o, payload_last_o, header_valid_o, sync_err_o, trunc_err_o};
    endfunction

    // Drive one word, clock it, then check the registered response.
    task automatic step(input string tag, input logic v, input logic [31:0] d,
                        input logic [4:0] ef, input logic [31:0] ep, input logic [3:0] ebe);
        lane_valid_i = v;
        lane_byte_i  = d;
        @(posedge clk);
        #1;
        check({tag, ".flags"}, flags(), {27'b0, ef});
        check({tag, ".data"}, payload_o, ep);
        check({tag, ".be"}, {28'b0, payload_be_o}, {28'b0, ebe});
    endtask

    task automatic hdr(input string tag, input logic [1:0] evc, input logic [5:0] edt,
                       input logic [15:0] ewc);
        check(tag, {8'b0, vc_o, dt_o, wc_o}, {8'b0, evc, edt, ewc});
    endtask

    task automatic good_burst(input string tag);
        step({tag, ".sync"}, 1'b1, SYNC, F_NONE, '0, '0);
        step({tag, ".hdr"}, 1'b1, 32'h0000082A, F_HV, '0, '0);
        hdr({tag, ".fields"}, 2'd0, 6'h2A, 16'h0008);
        step({tag, ".p0"}, 1'b1, 32'h11111111, F_PV, 32'h11111111, 4'hF);
        step({tag, ".p1"}, 1'b1, 32'h22222222, F_PV | F_LAST, 32'h22222222, 4'hF);
        step({tag, ".crc"}, 1'b1, 32'hC0C0C0C0, F_NONE, '0, '0);
        step({tag, ".end"}, 1'b0, '0, F_NONE, '0, '0);
        step({tag, ".gap"}, 1'b0, '0, F_NONE, '0, '0);
    endtask

    initial begin
        reset_i      = 1'b1;
        lane_valid_i = 1'b0;
        lane_byte_i  = '0;
        #3;
        check("rst.flags", flags(), '0);
        check("rst.data", payload_o, '0);
        hdr("rst.hdr", 2'd0, 6'h00, 16'h0000);
        @(posedge clk);
        #1;
        reset_i = 1'b0;
        step("idle", 1'b0, '0, F_NONE, '0, '0);

        good_burst("s1");

        // wc=5, vc=1, RAW10
        step("s2.sync", 1'b1, SYNC, F_NONE, '0, '0);
        step("s2.hdr", 1'b1, 32'h0000056B, F_HV, '0, '0);
        hdr("s2.fields", 2'd1, 6'h2B, 16'h0005);
        step("s2.p0", 1'b1, 32'hAAAAAAAA, F_PV, 32'hAAAAAAAA, 4'hF);
        step("s2.p1", 1'b1, 32'h000000BB, F_PV | F_LAST, 32'h000000BB, 4'b0001);
        step("s2.crc", 1'b1, 32'h5A5A5A5A, F_NONE, '0, '0);
        step("s2.end", 1'b0, '0, F_NONE, '0, '0);

        // short packet
        step("s3.sync", 1'b1, SYNC, F_NONE, '0, '0);
        step("s3.hdr", 1'b1, 32'h00000100, F_HV, '0, '0);
        hdr("s3.fields", 2'd0, 6'h00, 16'h0001);
        step("s3.junk", 1'b1, 32'h12345678, F_NONE, '0, '0);
        step("s3.end", 1'b0, '0, F_NONE, '0, '0);

        // bad sync
        step("s4.bad", 1'b1, 32'hB8B8B800, F_SE, '0, '0);
        step("s4.nohdr", 1'b1, 32'h0000082A, F_NONE, '0, '0);
        hdr("s4.hold", 2'd0, 6'h00, 16'h0001);
        step("s4.nosync", 1'b1, SYNC, F_NONE, '0, '0);
        step("s4.end", 1'b0, '0, F_NONE, '0, '0);
        step("s4.gap", 1'b0, '0, F_NONE, '0, '0);
        good_burst("s4b");

        // truncation
        step("s5.sync", 1'b1, SYNC, F_NONE, '0, '0);
        step("s5.hdr", 1'b1, 32'h0000102A, F_HV, '0, '0);
        hdr("s5.fields", 2'd0, 6'h2A, 16'h0010);
        step("s5.p0", 1'b1, 32'h01020304, F_PV, 32'h01020304, 4'hF);
        step("s5.p1", 1'b1, 32'h05060708, F_PV, 32'h05060708, 4'hF);
        step("s5.drop", 1'b0, '0, F_TE, '0, '0);
        step("s5.gap", 1'b0, '0, F_NONE, '0, '0);
        good_burst("s5b");

        // asynchronous reset mid-payload
        step("s6.sync", 1'b1, SYNC, F_NONE, '0, '0);
        step("s6.hdr", 1'b1, 32'h0000102A, F_HV, '0, '0);
        step("s6.p0", 1'b1, 32'hDEADBEEF, F_PV, 32'hDEADBEEF, 4'hF);
        #2;
        reset_i = 1'b1;
        #1;
        check("s6.rst.flags", flags(), '0);
        check("s6.rst.data", payload_o, '0);
        hdr("s6.rst.hdr", 2'd0, 6'h00, 16'h0000);
        lane_valid_i = 1'b0;
        @(posedge clk);
        #1;
        check("s6.rst.hold", flags(), '0);
        reset_i = 1'b0;
        step("s6.gap", 1'b0, '0, F_NONE, '0, '0);
        good_burst("s6b");

        // maximum word count
        step("s7.sync", 1'b1, SYNC, F_NONE, '0, '0);
        step("s7.hdr", 1'b1, 32'h00FFFF2A, F_HV, '0, '0);
        hdr("s7.fields", 2'd0, 6'h2A, 16'hFFFF);
        step("s7.p0", 1'b1, 32'h0BADF00D, F_PV, 32'h0BADF00D, 4'hF);
        step("s7.drop", 1'b0, '0, F_TE, '0, '0);
        step("s7.gap", 1'b0, '0, F_NONE, '0, '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
